sgdmac_write: RTL

Write engine of the scatter-gather DMA, directly downstream of the data buffer that the read engine fills. Each command carries a destination address and byte count. The block drains the buffer and emits AXI3 write bursts of up to 16 × 4-byte beats (64 B per burst). It waits for each write response before issuing the next burst, and signals idle to the descriptor unit.

---
 rtl/sgdmac_pkg.sv | 30 +++
 rtl/sgdmac_write_if.sv | 32 +++
 rtl/sgdmac_write.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sgdmac_pkg.sv
// rtl/sgdmac_pkg.sv - shared scatter-gather DMA types and AXI constants
package sgdmac_pkg;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_AW_REQ,
    WR_W_DATA,
    WR_B_WAIT
  } wr_state_e;

  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         BURST_BYTES = 64;
  localparam int         MAX_BEATS   = 16;

  typedef struct packed {
    logic [31:0] dst_addr;
    logic [15:0] byte_count;
  } sgdmac_cmd_t;

  // Full bursts while at least 64 B remain, otherwise the word-count tail.
  function automatic logic [3:0] burst_awlen(input logic [15:0] remain);
    if (remain >= 16'(BURST_BYTES)) begin
      return 4'(MAX_BEATS - 1);
    end
    return remain[5:2] - 4'd1;
  endfunction

endpackage

// File: rtl/sgdmac_write_if.sv
// rtl/sgdmac_write_if.sv - AXI3 write channel bundle (AW, W, B)
interface sgdmac_write_if;
  logic [3:0]  awid_o;
  logic [31:0] awaddr_o;
  logic [3:0]  awlen_o;
  logic [2:0]  awsize_o;
  logic [1:0]  awburst_o;
  logic        awvalid_o;
  logic        awready_i;
  logic [3:0]  wid_o;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast_o;
  logic        wvalid_o;
  logic        wready_i;
  logic [3:0]  bid_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i;
  logic        bready_o;

  modport master (
    output awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
    output wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o,
    input  awready_i, wready_i, bid_i, bresp_i, bvalid_i
  );

  modport slave (
    input  awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
    input  wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o,
    output awready_i, wready_i, bid_i, bresp_i, bvalid_i
  );
endinterface

// File: rtl/sgdmac_write.sv
// rtl/sgdmac_write.sv - DMA write engine: drains the data buffer into AXI3 write bursts
module sgdmac_write
  import sgdmac_pkg::*;
#(
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [47:0]                   cmd_i,
  output logic                          done_o,
  output logic                          error_o,
  sgdmac_write_if.master                axi,
  input  logic                          fifo_empty_i,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_i,
  input  logic [31:0]                   fifo_rdata_i,
  output logic                          fifo_rden_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wr_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] remain_q, remain_d;
  logic        awvalid_q, awvalid_d;
  logic [3:0]  awlen_q, awlen_d;
  logic [3:0]  beat_lim_q, beat_lim_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        error_q, error_d;

  sgdmac_cmd_t cmd;
  logic [3:0]  len_calc;
  logic [CW-1:0] words_needed;
  logic        w_valid;
  logic        w_last;
  logic        w_fire;
  logic        b_ready;
  logic        unused_inputs;

  assign cmd           = cmd_i;
  assign len_calc      = burst_awlen(remain_q);
  assign words_needed  = CW'({1'b0, len_calc}) + CW'(1);
  assign unused_inputs = ^{axi.bid_i, axi.bresp_i[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WR_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      awvalid_q  <= 1'b0;
      awlen_q    <= 4'hF;
      beat_lim_q <= '0;
      beat_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      awvalid_q  <= awvalid_d;
      awlen_q    <= awlen_d;
      beat_lim_q <= beat_lim_d;
      beat_cnt_q <= beat_cnt_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    awvalid_d  = awvalid_q;
    awlen_d    = awlen_q;
    beat_lim_d = beat_lim_q;
    beat_cnt_d = beat_cnt_q;
    error_d    = error_q;
    w_valid    = 1'b0;
    w_last     = 1'b0;
    w_fire     = 1'b0;
    b_ready    = 1'b0;

    case (state_q)
      WR_IDLE: begin
        if (start_i) begin
          addr_d   = cmd.dst_addr;
          remain_d = {cmd.byte_count[15:2], 2'b00};
          error_d  = 1'b0;
          if (cmd.byte_count[15:2] != 14'd0) begin
            state_d = WR_AW_REQ;
          end
        end
      end

      WR_AW_REQ: begin
        // The whole burst must already sit in the buffer before AW is offered,
        // so W never has to stall mid-burst on an empty buffer.
        if (!awvalid_q) begin
          if (fifo_cnt_i >= words_needed) begin
            awvalid_d = 1'b1;
            awlen_d   = len_calc;
          end
        end else if (axi.awready_i) begin
          awvalid_d  = 1'b0;
          beat_lim_d = awlen_q;
          beat_cnt_d = '0;
          addr_d     = addr_q + 32'(BURST_BYTES);
          remain_d   = (remain_q >= 16'(BURST_BYTES)) ? remain_q - 16'(BURST_BYTES) : 16'd0;
          state_d    = WR_W_DATA;
        end
      end

      WR_W_DATA: begin
        w_valid = !fifo_empty_i;
        w_last  = (beat_cnt_q == beat_lim_q);
        w_fire  = w_valid && axi.wready_i;
        if (w_fire) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (w_last) begin
            state_d = WR_B_WAIT;
          end
        end
      end

      WR_B_WAIT: begin
        b_ready = 1'b1;
        if (axi.bvalid_i) begin
          // A bad response is recorded but the command carries on.
          if (axi.bresp_i[1]) begin
            error_d = 1'b1;
          end
          state_d = (remain_q == 16'd0) ? WR_IDLE : WR_AW_REQ;
        end
      end

      default: begin
        state_d = WR_IDLE;
      end
    endcase
  end

  assign done_o        = (state_q == WR_IDLE);
  assign error_o       = error_q;

  assign axi.awid_o    = 4'h0;
  assign axi.awaddr_o  = addr_q;
  assign axi.awlen_o   = awlen_q;
  assign axi.awsize_o  = SIZE_4B;
  assign axi.awburst_o = BURST_INCR;
  assign axi.awvalid_o = awvalid_q;

  assign axi.wid_o     = 4'h0;
  assign axi.wdata_o   = fifo_rdata_i;
  assign axi.wstrb_o   = 4'hF;
  assign axi.wlast_o   = w_last;
  assign axi.wvalid_o  = w_valid;
  assign axi.bready_o  = b_ready;

  assign fifo_rden_o   = w_fire;

endmodule
